// File: rtl/stage_controller_multi_if.sv
// Stage controller bundle: round start, PE status, stage broadcast and result handshake.
// master = the stage controller, slave = the round source, PE array and result consumer.
// The result handshake is valid/ready; result_valid is held until result_ready is seen.
interface stage_controller_multi_if #(
   parameter int PU_COUNT                = 18,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int CYCLE_COUNTER_WIDTH     = 32,
   parameter int STAGE_WIDTH             = 3
);
   logic                               new_round_start;
   logic [PU_COUNT-1:0]                busy_PE;
   logic [PU_COUNT-1:0]                odd_clusters_PE;
   logic                               result_ready;
   logic [STAGE_WIDTH-1:0]             global_stage;
   logic                               result_valid;
   logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
   logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter;
   logic                               timeout;

   modport master (
      input  new_round_start, busy_PE, odd_clusters_PE, result_ready,
      output global_stage, result_valid, iteration_counter, cycle_counter, timeout
   );

   modport slave (
      output new_round_start, busy_PE, odd_clusters_PE, result_ready,
      input  global_stage, result_valid, iteration_counter, cycle_counter, timeout
   );
endinterface

// File: rtl/stage_controller_multi.sv
// Global decode stage sequencer for one PE array (IDLE/LOADING/GROW/MERGE/PEELING/RESULT).
// Latency: PE busy/odd seen one cycle late (registered OR); new stage visible one edge after decision.
// Backpressure: result_valid held until result_ready; starts arriving while result_valid=1 are dropped.
// Optional PEELING stage enabled by defining STAGE_CTRL_PEELING_EN; otherwise MERGE goes straight to RESULT.
module stage_controller_multi #(
   parameter int CODE_DISTANCE_X         = 3,
   parameter int CODE_DISTANCE_Z         = 2,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int MAX_ITERATIONS          = 255,
   parameter int MAXIMUM_DELAY           = 2,
   parameter int LOADING_CYCLES          = 1,
   parameter int CYCLE_COUNTER_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   stage_controller_multi_if.master bus
);
   localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z;
   localparam int PU_COUNT    = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
   localparam int STAGE_WIDTH = 3;
   localparam int DELAY_SPAN  = (MAXIMUM_DELAY > LOADING_CYCLES) ? MAXIMUM_DELAY : LOADING_CYCLES;
   localparam int DELAY_WIDTH = (DELAY_SPAN < 2) ? 1 : $clog2(DELAY_SPAN + 1);

   localparam logic [STAGE_WIDTH-1:0] ST_IDLE    = STAGE_WIDTH'(0);
   localparam logic [STAGE_WIDTH-1:0] ST_LOADING = STAGE_WIDTH'(1);
   localparam logic [STAGE_WIDTH-1:0] ST_GROW    = STAGE_WIDTH'(2);
   localparam logic [STAGE_WIDTH-1:0] ST_MERGE   = STAGE_WIDTH'(3);
   localparam logic [STAGE_WIDTH-1:0] ST_PEELING = STAGE_WIDTH'(4);
   localparam logic [STAGE_WIDTH-1:0] ST_RESULT  = STAGE_WIDTH'(5);

`ifdef STAGE_CTRL_PEELING_EN
   localparam logic [STAGE_WIDTH-1:0] ST_AFTER_MERGE = ST_PEELING;
`else
   localparam logic [STAGE_WIDTH-1:0] ST_AFTER_MERGE = ST_RESULT;
`endif

   logic [STAGE_WIDTH-1:0]             stage, next_stage, prev_stage;
   logic [DELAY_WIDTH-1:0]             delay_cnt;
   logic [PU_COUNT-1:0]                busy_vec, odd_vec;
   logic                               busy_r, odd_r;
   logic                               result_valid_r, timeout_r;
   logic [ITERATION_COUNTER_WIDTH-1:0] iter_cnt;
   logic [CYCLE_COUNTER_WIDTH-1:0]     cyc_cnt;
   logic                               settled, load_done, iter_limit;
   logic                               loading_entry, grow_first, timeout_set;

   assign busy_vec   = bus.busy_PE;
   assign odd_vec    = bus.odd_clusters_PE;
   assign settled    = (delay_cnt == DELAY_WIDTH'(MAXIMUM_DELAY));
   assign load_done  = (delay_cnt == DELAY_WIDTH'(LOADING_CYCLES - 1));
   assign iter_limit = (iter_cnt == ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS));

   // State register; prev_stage remembers last cycle's stage for GROW-entry detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage      <= ST_IDLE;
         prev_stage <= ST_IDLE;
      end else begin
         stage      <= next_stage;
         prev_stage <= stage;
      end
   end

   // Next-state decision, using only the registered busy/odd reductions
   always_comb begin
      next_stage = ST_IDLE;
      case (stage)
         ST_IDLE:    next_stage = (bus.new_round_start && !result_valid_r) ? ST_LOADING : ST_IDLE;
         ST_LOADING: next_stage = load_done ? ST_GROW : ST_LOADING;
         ST_GROW:    next_stage = ST_MERGE;
         ST_MERGE: begin
            if (!settled || busy_r)  next_stage = ST_MERGE;
            else if (!odd_r)         next_stage = ST_AFTER_MERGE;
            else if (iter_limit)     next_stage = ST_RESULT;
            else                     next_stage = ST_GROW;
         end
         ST_PEELING: next_stage = (!settled || busy_r) ? ST_PEELING : ST_RESULT;
         ST_RESULT:  next_stage = ST_IDLE;
         default:    next_stage = ST_IDLE;
      endcase
   end

   // Outputs and stage-derived strobes
   always_comb begin
      bus.global_stage      = stage;
      bus.result_valid      = result_valid_r;
      bus.iteration_counter = iter_cnt;
      bus.cycle_counter     = cyc_cnt;
      bus.timeout           = timeout_r;
      loading_entry         = (stage != ST_LOADING) && (next_stage == ST_LOADING);
      grow_first            = (stage == ST_GROW) && (prev_stage != ST_GROW);
      timeout_set           = (stage == ST_MERGE) && (next_stage == ST_RESULT) && odd_r;
   end

   // Register the PE OR-reductions once; every decision sees them a cycle late
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= 1'b0;
         odd_r  <= 1'b0;
      end else begin
         busy_r <= |busy_vec;
         odd_r  <= |odd_vec;
      end
   end

   // Shared dwell counter for LOADING length and MERGE/PEELING settle time; cleared on stage change
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         delay_cnt <= '0;
      else if (next_stage != stage)
         delay_cnt <= '0;
      else if (stage == ST_LOADING || ((stage == ST_MERGE || stage == ST_PEELING) && !settled))
         delay_cnt <= delay_cnt + 1'b1;
   end

   // Iteration count and timeout flag, both cleared when a round is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iter_cnt  <= '0;
         timeout_r <= 1'b0;
      end else if (loading_entry) begin
         iter_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (grow_first)  iter_cnt  <= iter_cnt + 1'b1;
         if (timeout_set) timeout_r <= 1'b1;
      end
   end

   // Saturating decode-latency counter, restarted at 1 in LOADING, frozen in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cyc_cnt <= '0;
      else if (stage == ST_LOADING)
         cyc_cnt <= CYCLE_COUNTER_WIDTH'(1);
      else if ((stage == ST_GROW || stage == ST_MERGE || stage == ST_PEELING || stage == ST_RESULT)
               && (cyc_cnt != '1))
         cyc_cnt <= cyc_cnt + 1'b1;
   end

   // Result handshake: raised leaving RESULT, dropped when the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         result_valid_r <= 1'b0;
      else if (stage == ST_RESULT)
         result_valid_r <= 1'b1;
      else if (bus.result_ready)
         result_valid_r <= 1'b0;
   end
endmodule
